// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ write-domain requesters.
// Optional saturating write-error counter enabled by defining WRERR_CNT_EN.

module fifo_wr_lane #(
  parameter int DW = 8
) (
  input  logic          sel,
  input  logic          acc,
  input  logic [DW-1:0] din,
  output logic          ack,
  output logic [DW-1:0] dout
);
  assign ack  = sel & acc;
  assign dout = ack ? din : '0;
endmodule

module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int BURST = 4,
  localparam int GW   = (NREQ  > 1) ? $clog2(NREQ)  : 1,
  localparam int CW   = (BURST > 1) ? $clog2(BURST) : 1
) (
  input  logic               wrclk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] reqdata,
  output logic [NREQ-1:0]    ack,
  output logic               wren,
  output logic [DW-1:0]      wrdata,
  input  logic               full,
  input  logic               wrerr,
  output logic [GW-1:0]      grant,
  output logic               busy
`ifdef WRERR_CNT_EN
  , output logic [7:0]       errcnt
`endif
);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t  state;
  logic [GW-1:0] last;
  logic [CW-1:0] bcnt;

  logic [NREQ-1:0][DW-1:0] rdat;
  logic [NREQ-1:0][DW-1:0] lane_dat;
  logic          own_req, accept, found;
  logic [GW-1:0] nxt;
  int            idx;

  assign rdat    = reqdata;
  assign busy    = (state == S_BURST);
  assign own_req = req[grant];
  // rst gates accept so an in-flight word is never acked on the reset edge
  assign accept  = busy & own_req & ~full & ~rst;
  assign wren    = accept;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    fifo_wr_lane #(.DW(DW)) u_lane (
      .sel  (grant == GW'(i)),
      .acc  (accept),
      .din  (rdat[i]),
      .ack  (ack[i]),
      .dout (lane_dat[i])
    );
  end

  always_comb begin
    wrdata = '0;
    for (int i = 0; i < NREQ; i++) wrdata = wrdata | lane_dat[i];
  end

  // search starts just after the previous owner
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        nxt   = GW'(idx);
      end
    end
  end

  always_ff @(posedge wrclk) begin
    if (rst) begin
      state <= S_IDLE;
      grant <= '0;
      last  <= GW'(NREQ-1);
      bcnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            grant <= nxt;
            bcnt  <= '0;
            state <= S_BURST;
          end
        end
        S_BURST: begin
          if (!own_req || (accept && bcnt == CW'(BURST-1))) begin
            state <= S_IDLE;
            last  <= grant;
          end else if (accept) begin
            bcnt <= bcnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef WRERR_CNT_EN
  always_ff @(posedge wrclk) begin
    if (rst)                            errcnt <= '0;
    else if (wrerr && errcnt != 8'hFF)  errcnt <= errcnt + 8'd1;
  end
`else
  logic unused_wrerr;
  assign unused_wrerr = wrerr;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, round robin, short burst, full stall, mid-burst reset.
// Error counter checks run only when WRERR_CNT_EN is defined.

module tb_fifo_wr_arbiter;
  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int BURST = 4;
  localparam int GW    = 2;

  logic               wrclk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] reqdata;
  logic [NREQ-1:0]    ack;
  logic               wren;
  logic [DW-1:0]      wrdata;
  logic               full;
  logic               wrerr;
  logic [GW-1:0]      grant;
  logic               busy;
`ifdef WRERR_CNT_EN
  logic [7:0]         errcnt;
`endif

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST(BURST)) dut (
    .wrclk   (wrclk),
    .rst     (rst),
    .req     (req),
    .reqdata (reqdata),
    .ack     (ack),
    .wren    (wren),
    .wrdata  (wrdata),
    .full    (full),
    .wrerr   (wrerr),
    .grant   (grant),
    .busy    (busy)
`ifdef WRERR_CNT_EN
    , .errcnt (errcnt)
`endif
  );

  always #5 wrclk = ~wrclk;

  int n_chk  = 0;
  int n_fail = 0;
  int cnt  [NREQ];
  int left [NREQ];   // words left before requester drops; 255 = endless

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req[i] = (left[i] != 0);
      reqdata[i*DW +: DW] = 8'(i*16 + (cnt[i] % 16));
    end
  endtask

  // advance one edge; requesters present their next word after an ack
  task automatic tick();
    logic [NREQ-1:0] a;
    a = ack;
    @(posedge wrclk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (a[i]) begin
        cnt[i]++;
        if (left[i] != 255 && left[i] > 0) left[i]--;
      end
    drive();
    #1;
  endtask

  task automatic chk_word(input string tag, input int g, input int d);
    chk({tag, "_wren"}, wren, 1);
    chk({tag, "_ack"}, ack, 32'(1 << g));
    chk({tag, "_data"}, wrdata, d);
  endtask

  initial begin
    rst = 1'b1; full = 1'b0; wrerr = 1'b0;
    for (int i = 0; i < NREQ; i++) begin cnt[i] = 0; left[i] = 255; end
    drive();

    // reset with all requesters active
    tick();
    chk("rst1_wren", wren, 0); chk("rst1_ack", ack, 0); chk("rst1_busy", busy, 0);
    chk("rst1_data", wrdata, 0);
    tick();
    chk("rst2_wren", wren, 0); chk("rst2_ack", ack, 0); chk("rst2_busy", busy, 0);
    rst = 1'b0;
    #1;

    // round robin 0,1,2,3,0 with one arbitration cycle between bursts
    for (int b = 0; b < 5; b++) begin
      chk("rr_idle_busy", busy, 0);
      chk("rr_idle_wren", wren, 0);
      tick();
      chk("rr_busy", busy, 1);
      chk("rr_grant", grant, b % 4);
      for (int w = 0; w < 4; w++) begin
        chk_word("rr", b % 4, (b % 4) * 16 + (b / 4) * 4 + w);
        tick();
      end
    end

    // short burst: only requester 2, two words
    for (int i = 0; i < NREQ; i++) left[i] = 0;
    left[2] = 2;
    drive(); #1;
    chk("sb_idle", busy, 0);
    tick();
    chk("sb_grant", grant, 2);
    chk_word("sb0", 2, 8'h24); tick();
    chk_word("sb1", 2, 8'h25); tick();
    chk("sb_drop_wren", wren, 0);
    chk("sb_drop_busy", busy, 1);
    tick();
    chk("sb_exit_busy", busy, 0);
    left[3] = 1;
    drive(); #1;
    tick();
    chk("sb_next_grant", grant, 3);
    chk_word("sb3", 3, 8'h34); tick();
    tick();
    chk("sb3_exit_busy", busy, 0);

    // full stall during grant 1; requester 3 arrives and must wait
    left[1] = 4;
    drive(); #1;
    tick();
    chk("fs_grant", grant, 1);
    chk_word("fs0", 1, 8'h14); tick();
    chk_word("fs1", 1, 8'h15); tick();
    full = 1'b1; left[3] = 255;
    drive(); #1;
    for (int c = 0; c < 5; c++) begin
      chk("fs_wren", wren, 0); chk("fs_ack", ack, 0);
      chk("fs_grant_hold", grant, 1); chk("fs_busy", busy, 1);
      tick();
    end
    full = 1'b0;
    #1;
    chk_word("fs2", 1, 8'h16); tick();
    chk_word("fs3", 1, 8'h17); tick();
    chk("fs_exit_busy", busy, 0);

    // reset after the first word of grant 3
    tick();
    chk("mr_grant", grant, 3);
    chk_word("mr0", 3, 8'h35); tick();
    rst = 1'b1;
    #1;
    chk("mr_inflight_wren", wren, 0);
    chk("mr_inflight_ack", ack, 0);
    chk("mr_inflight_data", wrdata, 0);
    tick();
    chk("mr_busy", busy, 0); chk("mr_wren", wren, 0);
    rst = 1'b0;
    left[0] = 255; left[1] = 0; left[2] = 0; left[3] = 255;
    drive(); #1;
    chk("mr_req", req, 4'b1001);
    tick();
    chk("mr_after_grant", grant, 0);
    chk("mr_after_busy", busy, 1);

`ifdef WRERR_CNT_EN
    for (int i = 0; i < NREQ; i++) left[i] = 0;
    drive();
    rst = 1'b1; tick(); rst = 1'b0; #1;
    chk("ec_reset", errcnt, 0);
    for (int p = 0; p < 3; p++) begin
      wrerr = 1'b1; tick(); wrerr = 1'b0; tick();
    end
    chk("ec_three", errcnt, 3);
    wrerr = 1'b1;
    for (int p = 0; p < 300; p++) tick();
    wrerr = 1'b0;
    chk("ec_sat", errcnt, 255);
    rst = 1'b1; tick(); rst = 1'b0; #1;
    chk("ec_clear", errcnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
